midi_voice_allocator: RTL and testbench
=======================================

Name: midi_voice_allocator

Overview:
Parametrised MIDI event-to-voice allocator that replaces the fixed 4-voice round-robin note handler inside the MIDI player top levels. It consumes framed events from midi_uart via its valid/ack handshake and assigns notes to NUM_VOICES voices: free voices are used first, and the least-recently-allocated voice is stolen when none is free. It drives per-voice gate, note, velocity and tone frequency into the voice array, plus mod-wheel and pitch-bend values for the filter tables.

Parameters:
NUM_VOICES, 4, voice count; 2..16.
RETRIG_CYCLES, 16, clk cycles a stolen or retriggered voice is held gate-low before re-gating; >=1.
CHANNEL_FILTER, 1, 1 = accept only events matching midi_channel; 0 = omni.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
midi_event_valid  in  1  event available from midi_uart.
midi_command  in  8  status byte.
midi_parameter_1  in  7  note / controller number / bend LSB.
midi_parameter_2  in  7  velocity / controller value / bend MSB.
midi_event_ack  out  1  one-cycle event acknowledge.
midi_channel  in  4  channel to accept when CHANNEL_FILTER=1.
busy  out  1  high while an event is being processed.
voice_gate  out  NUM_VOICES  per-voice gate.
voice_note  out  7*NUM_VOICES  note per voice; voice i occupies [7i+6:7i].
voice_velocity  out  7*NUM_VOICES  velocity per voice, same packing.
voice_frequency  out  16*NUM_VOICES  tone_freq per voice from midi_note_to_tone_freq.
mod_wheel  out  7  last CC 0x01 value.
pitch_bend  out  14  last pitch-bend value {p2,p1}.

Behaviour:
- Reset values: all gates 0; notes, velocities and frequencies 0; mod_wheel 64; pitch_bend 0x2000; ack 0; busy 0; LRU ranks set to voice index (voice 0 newest); FSM in IDLE.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE: when valid is high, latch command and parameters, pulse ack for exactly one cycle, raise busy, go to SCAN. Valid must drop before the next ack is issued, so no double ack.
- Rejected events are acked and dropped with no output change and no SCAN. An event is rejected when CHANNEL_FILTER=1 and command[3:0] != midi_channel, or when command[7] = 0.
- SCAN: examines voice k = 0..NUM_VOICES-1, one per cycle. It records, each at the lowest index that qualifies:
  - first gated voice whose note equals p1 (match);
  - first voice with gate=0 and no pending retrigger (free);
  - the voice with LRU rank NUM_VOICES-1 (oldest).
- After NUM_VOICES cycles, go to COMMIT. COMMIT lasts one cycle, then return to IDLE and drop busy.
- Latency: outputs update in the cycle after COMMIT, i.e. event-latch cycle + NUM_VOICES + 2.
- Note-on 0x9n with velocity > 0, target chosen in priority order:
  - match: retrigger;
  - free: gate immediately;
  - otherwise oldest: steal with retrigger.
- Applying a note-on: write note, velocity and frequency. Set the target's LRU rank to 0 and increment every rank lower than the target's old rank.
- Retrigger: gate forced 0 for RETRIG_CYCLES cycles via a per-voice down-counter, then 1. A note-off for that note arriving during the countdown cancels the re-gate.
- Note-off 0x8n, or note-on with velocity 0: every gated or retrigger-pending voice with note == p1 gets gate 0 and its counter cleared. Note and frequency are retained so the release tail keeps its pitch. No match means no change.
- CC 0xBn:
  - p1 = 0x01: mod_wheel <= p2.
  - p1 = 0x7B (all notes off): all gates 0 and all counters cleared.
  - Other controllers are ignored.
- Pitch bend 0xEn: pitch_bend <= {p2, p1}.
- Retrigger counters run every cycle, in every state.
- rst during SCAN or COMMIT aborts the event with no partial writes; all outputs return to reset values the next cycle.

Optional Feature:
SUSTAIN_PEDAL_EN:
- Defined: CC 0x40 with p2 >= 64 sets sustain; p2 < 64 clears it.
- While sustain is set, note-off marks matching voices as held (gate stays 1).
- Clearing sustain drops the gate of every held voice in the same COMMIT.
- Held voices count as non-free and remain steal candidates.
- All-notes-off clears held flags.
- Undefined: CC 0x40 is ignored and no held-flag logic is synthesised.

Test Plan:
1. NUM_VOICES=4, note-on 0x90 60 100 -> ack one cycle; 6 cycles later voice0 gate=1, note=60, vel=100, freq = midi_note_to_tone_freq(60); busy low.
2. Note-ons 60, 62, 64, 67, then 69 -> voices 0-3 filled in order. 69 steals voice0: gate 0 for 16 cycles, then 1 with note 69.
3. Note-on 60 twice -> second targets voice0 via match. Retrigger pulse of 16 low cycles; no other voice gated.
4. Note-on 60, note-on 62, then 0x90 60 0 -> voice0 gate 0 with note still 60; voice1 gate stays 1.
5. CHANNEL_FILTER=1, midi_channel=2: 0x93 60 100 -> acked, no gate change. 0xB2 0x01 20 -> mod_wheel=20. 0xE2 0x00 0x7F -> pitch_bend=0x3F80.
6. Four notes gated, 0xB0 0x7B 0 -> all gates 0. Separately, rst asserted in the 2nd SCAN cycle -> next cycle all outputs at reset values, and no write from the aborted event appears.

Source files
------------

// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator
//   Assigns framed MIDI events to NUM_VOICES voices. A note-on goes to a voice
//   already sounding that note (retrigger), else the lowest free voice, else
//   the least-recently-allocated voice is stolen and retriggered. Each event is
//   scanned one voice per cycle (IDLE -> SCAN x NUM_VOICES -> COMMIT).
//
//   Optional feature: define SUSTAIN_PEDAL_EN to honour CC 0x40 (sustain).
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   midi_event_valid/_ack        event handshake with midi_uart (ack is 1 cycle)
//   midi_command, midi_parameter_1/_2   status byte and data bytes
//   midi_channel                 accepted channel when CHANNEL_FILTER=1
//   busy                         high during SCAN and COMMIT
//   voice_gate/note/velocity/frequency  per-voice outputs, voice i at slice i
//   mod_wheel, pitch_bend        last CC 0x01 value, last bend {p2,p1}
module midi_voice_allocator #(
    parameter int unsigned NUM_VOICES     = 4,
    parameter int unsigned RETRIG_CYCLES  = 16,
    parameter int unsigned CHANNEL_FILTER = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       midi_event_valid,
    input  logic [7:0]                 midi_command,
    input  logic [6:0]                 midi_parameter_1,
    input  logic [6:0]                 midi_parameter_2,
    output logic                       midi_event_ack,
    input  logic [3:0]                 midi_channel,
    output logic                       busy,
    output logic [NUM_VOICES-1:0]      voice_gate,
    output logic [7*NUM_VOICES-1:0]    voice_note,
    output logic [7*NUM_VOICES-1:0]    voice_velocity,
    output logic [16*NUM_VOICES-1:0]   voice_frequency,
    output logic [6:0]                 mod_wheel,
    output logic [13:0]                pitch_bend
);

    localparam int unsigned IdxW = $clog2(NUM_VOICES);
    localparam int unsigned CntW = $clog2(RETRIG_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;

    state_e                state_q, state_d;
    logic                  ack_q, ack_d;
    logic [3:0]            cmd_q, cmd_d;          // status nibble only
    logic [6:0]            p1_q, p1_d, p2_q, p2_d;
    logic [IdxW-1:0]       scan_q, scan_d;
    logic                  match_found_q, match_found_d, free_found_q, free_found_d;
    logic [IdxW-1:0]       match_idx_q, match_idx_d, free_idx_q, free_idx_d;
    logic [IdxW-1:0]       oldest_q, oldest_d;
    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [6:0]            note_q [NUM_VOICES], note_d [NUM_VOICES];
    logic [6:0]            vel_q  [NUM_VOICES], vel_d  [NUM_VOICES];
    logic [15:0]           freq_q [NUM_VOICES], freq_d [NUM_VOICES];
    logic [IdxW-1:0]       rank_q [NUM_VOICES], rank_d [NUM_VOICES];  // 0 = newest
    logic [CntW-1:0]       cnt_q  [NUM_VOICES], cnt_d  [NUM_VOICES];  // retrigger countdown
    logic [6:0]            mod_q, mod_d;
    logic [13:0]           bend_q, bend_d;
`ifdef SUSTAIN_PEDAL_EN
    logic [NUM_VOICES-1:0] held_q, held_d;
    logic                  sustain_q, sustain_d;
`endif

    logic                  reject;
    logic                  is_note_on, is_note_off;
    logic [IdxW-1:0]       target;
    logic                  retrig;

    // Equal-tempered pitch in Hz: top octave (notes 120..131) halved per octave down.
    function automatic logic [15:0] midi_note_to_tone_freq(input logic [6:0] note);
        logic [6:0]  octave;
        logic [6:0]  semi;
        logic [15:0] top;
        octave = note / 7'd12;
        semi   = note % 7'd12;
        case (semi)
            7'd0:    top = 16'd8372;
            7'd1:    top = 16'd8870;
            7'd2:    top = 16'd9397;
            7'd3:    top = 16'd9956;
            7'd4:    top = 16'd10548;
            7'd5:    top = 16'd11175;
            7'd6:    top = 16'd11840;
            7'd7:    top = 16'd12544;
            7'd8:    top = 16'd13290;
            7'd9:    top = 16'd14080;
            7'd10:   top = 16'd14917;
            default: top = 16'd15804;
        endcase
        return top >> (7'd10 - octave);
    endfunction

    always_comb begin
        state_d       = state_q;
        ack_d         = 1'b0;
        cmd_d         = cmd_q;
        p1_d          = p1_q;
        p2_d          = p2_q;
        scan_d        = scan_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        oldest_d      = oldest_q;
        gate_d        = gate_q;
        note_d        = note_q;
        vel_d         = vel_q;
        freq_d        = freq_q;
        rank_d        = rank_q;
        cnt_d         = cnt_q;
        mod_d         = mod_q;
        bend_d        = bend_q;
`ifdef SUSTAIN_PEDAL_EN
        held_d        = held_q;
        sustain_d     = sustain_q;
`endif
        reject      = ((CHANNEL_FILTER != 0) && (midi_command[3:0] != midi_channel)) ||
                      !midi_command[7];
        is_note_on  = (cmd_q == 4'h9) && (p2_q != 7'd0);
        is_note_off = (cmd_q == 4'h8) || ((cmd_q == 4'h9) && (p2_q == 7'd0));
        target      = match_found_q ? match_idx_q : (free_found_q ? free_idx_q : oldest_q);
        retrig      = match_found_q || !free_found_q;

        // Retrigger countdowns run in every state; gate rises as the count leaves 1.
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (cnt_q[v] != '0) begin
                cnt_d[v] = cnt_q[v] - 1'b1;
                if (cnt_q[v] == CntW'(1)) gate_d[v] = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                // ack_q guard keeps a still-high valid from being acked twice
                if (midi_event_valid && !ack_q) begin
                    ack_d = 1'b1;
                    if (!reject) begin
                        cmd_d         = midi_command[7:4];
                        p1_d          = midi_parameter_1;
                        p2_d          = midi_parameter_2;
                        scan_d        = '0;
                        match_found_d = 1'b0;
                        free_found_d  = 1'b0;
                        state_d       = StScan;
                    end
                end
            end
            StScan: begin
                if (!match_found_q && gate_q[scan_q] && (note_q[scan_q] == p1_q)) begin
                    match_found_d = 1'b1;
                    match_idx_d   = scan_q;
                end
                if (!free_found_q && !gate_q[scan_q] && (cnt_q[scan_q] == '0)) begin
                    free_found_d = 1'b1;
                    free_idx_d   = scan_q;
                end
                if (rank_q[scan_q] == IdxW'(NUM_VOICES - 1)) oldest_d = scan_q;
                if (scan_q == IdxW'(NUM_VOICES - 1)) state_d = StCommit;
                else                                  scan_d  = scan_q + 1'b1;
            end
            StCommit: begin
                state_d = StIdle;
                if (is_note_on) begin
                    note_d[target] = p1_q;
                    vel_d[target]  = p2_q;
                    freq_d[target] = midi_note_to_tone_freq(p1_q);
                    gate_d[target] = !retrig;
                    cnt_d[target]  = retrig ? CntW'(RETRIG_CYCLES) : '0;
`ifdef SUSTAIN_PEDAL_EN
                    held_d[target] = 1'b0;
`endif
                    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                        if (IdxW'(v) == target)             rank_d[v] = '0;
                        else if (rank_q[v] < rank_q[target]) rank_d[v] = rank_q[v] + 1'b1;
                    end
                end else if (is_note_off) begin
                    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                        if ((gate_q[v] || (cnt_q[v] != '0)) && (note_q[v] == p1_q)) begin
`ifdef SUSTAIN_PEDAL_EN
                            if (sustain_q) begin
                                held_d[v] = 1'b1;
                            end else begin
                                gate_d[v] = 1'b0;
                                cnt_d[v]  = '0;
                            end
`else
                            gate_d[v] = 1'b0;
                            cnt_d[v]  = '0;
`endif
                        end
                    end
                end else if (cmd_q == 4'hB) begin
                    if (p1_q == 7'h01) mod_d = p2_q;
                    if (p1_q == 7'h7B) begin
                        gate_d = '0;
                        for (int unsigned v = 0; v < NUM_VOICES; v++) cnt_d[v] = '0;
`ifdef SUSTAIN_PEDAL_EN
                        held_d = '0;
`endif
                    end
`ifdef SUSTAIN_PEDAL_EN
                    if (p1_q == 7'h40) begin
                        sustain_d = p2_q[6];
                        if (!p2_q[6]) begin
                            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                                if (held_q[v]) begin
                                    gate_d[v] = 1'b0;
                                    cnt_d[v]  = '0;
                                end
                            end
                            held_d = '0;
                        end
                    end
`endif
                end else if (cmd_q == 4'hE) begin
                    bend_d = {p2_q, p1_q};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            ack_q         <= 1'b0;
            cmd_q         <= '0;
            p1_q          <= '0;
            p2_q          <= '0;
            scan_q        <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            oldest_q      <= '0;
            gate_q        <= '0;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= '0;
                vel_q[v]  <= '0;
                freq_q[v] <= '0;
                rank_q[v] <= IdxW'(v);
                cnt_q[v]  <= '0;
            end
            mod_q         <= 7'd64;
            bend_q        <= 14'h2000;
`ifdef SUSTAIN_PEDAL_EN
            held_q        <= '0;
            sustain_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ack_q         <= ack_d;
            cmd_q         <= cmd_d;
            p1_q          <= p1_d;
            p2_q          <= p2_d;
            scan_q        <= scan_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            oldest_q      <= oldest_d;
            gate_q        <= gate_d;
            note_q        <= note_d;
            vel_q         <= vel_d;
            freq_q        <= freq_d;
            rank_q        <= rank_d;
            cnt_q         <= cnt_d;
            mod_q         <= mod_d;
            bend_q        <= bend_d;
`ifdef SUSTAIN_PEDAL_EN
            held_q        <= held_d;
            sustain_q     <= sustain_d;
`endif
        end
    end

    assign midi_event_ack = ack_q;
    assign busy           = (state_q != StIdle);
    assign voice_gate     = gate_q;
    assign mod_wheel      = mod_q;
    assign pitch_bend     = bend_q;

    for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_pack
        assign voice_note[7*gv +: 7]       = note_q[gv];
        assign voice_velocity[7*gv +: 7]   = vel_q[gv];
        assign voice_frequency[16*gv +: 16] = freq_q[gv];
    end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb_midi_voice_allocator
//   Directed scenarios plus randomized event traffic for midi_voice_allocator
//   (NUM_VOICES=4, RETRIG_CYCLES=16, CHANNEL_FILTER=1). The reference model keeps
//   per-voice "sounding" flags with the absolute clock edge at which the gate
//   (re)opens, and an LRU list ordered newest-first.
module tb_midi_voice_allocator;
    localparam int NV = 4;
    localparam int RT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid;
    logic [7:0]        cmd;
    logic [6:0]        p1, p2;
    logic              ack;
    logic [3:0]        chan;
    logic              busy;
    logic [NV-1:0]     gate;
    logic [7*NV-1:0]   note, vel;
    logic [16*NV-1:0]  freq;
    logic [6:0]        mod;
    logic [13:0]       pb;

    midi_voice_allocator dut (
        .clk              (clk),
        .rst              (rst),
        .midi_event_valid (valid),
        .midi_command     (cmd),
        .midi_parameter_1 (p1),
        .midi_parameter_2 (p2),
        .midi_event_ack   (ack),
        .midi_channel     (chan),
        .busy             (busy),
        .voice_gate       (gate),
        .voice_note       (note),
        .voice_velocity   (vel),
        .voice_frequency  (freq),
        .mod_wheel        (mod),
        .pitch_bend       (pb)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int total = 0;
    int bad   = 0;

    // Reference model
    int m_note [NV];
    int m_vel  [NV];
    int m_freq [NV];
    int m_regate [NV];   // first edge after which the gate reads 1
    bit m_on [NV];       // voice is sounding (gated or awaiting re-gate)
    int m_mod, m_pb;
    int lru [$];         // front = newest

    function automatic int exp_freq(int n);
        int tbl [12] = '{8372, 8870, 9397, 9956, 10548, 11175,
                         11840, 12544, 13290, 14080, 14917, 15804};
        return tbl[n % 12] / (1 << (10 - n / 12));
    endfunction

    function automatic bit gate_at(int v, int e);
        return m_on[v] && (e >= m_regate[v]);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_note[v] = 0; m_vel[v] = 0; m_freq[v] = 0; m_regate[v] = 0; m_on[v] = 0;
        end
        lru.delete();
        for (int v = 0; v < NV; v++) lru.push_back(v);
        m_mod = 64;
        m_pb  = 'h2000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_gates();
        logic [NV-1:0] e;
        for (int v = 0; v < NV; v++) e[v] = gate_at(v, edge_n);
        check("gate", 32'(gate), 32'(e));
    endtask

    task automatic check_all();
        check_gates();
        for (int v = 0; v < NV; v++) begin
            check("note", 32'(note[7*v +: 7]), m_note[v]);
            check("vel",  32'(vel[7*v +: 7]),  m_vel[v]);
            check("freq", 32'(freq[16*v +: 16]), m_freq[v]);
        end
        check("mod_wheel", 32'(mod), m_mod);
        check("pitch_bend", 32'(pb), m_pb);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            check_gates();
        end
    endtask

    // Apply an accepted event latched at edge e0; it lands on edge e0+NV+1.
    task automatic model_commit(input int e0, input logic [7:0] c, input int a, input int b);
        int c_edge = e0 + NV + 1;
        int match = -1;
        int free_v = -1;
        int t;
        int hi = int'(c[7:4]);
        for (int k = 0; k < NV; k++) begin
            if (match < 0 && gate_at(k, e0 + k) && m_note[k] == a) match = k;
            if (free_v < 0 && !m_on[k]) free_v = k;
        end
        if (hi == 9 && b != 0) begin
            t = (match >= 0) ? match : ((free_v >= 0) ? free_v : lru[$]);
            m_note[t] = a;
            m_vel[t]  = b;
            m_freq[t] = exp_freq(a);
            m_on[t]   = 1;
            m_regate[t] = (match >= 0 || free_v < 0) ? c_edge + RT : c_edge;
            for (int i = 0; i < lru.size(); i++) begin
                if (lru[i] == t) begin
                    lru.delete(i);
                    break;
                end
            end
            lru.push_front(t);
        end else if (hi == 8 || hi == 9) begin
            for (int v = 0; v < NV; v++) if (m_on[v] && m_note[v] == a) m_on[v] = 0;
        end else if (hi == 'hB) begin
            if (a == 1) m_mod = b;
            if (a == 'h7B) for (int v = 0; v < NV; v++) m_on[v] = 0;
        end else if (hi == 'hE) begin
            m_pb = (b << 7) | a;
        end
    endtask

    task automatic send(input logic [7:0] c, input logic [6:0] a, input logic [6:0] b);
        bit rej;
        int e0;
        rej = (c[3:0] != chan) || !c[7];
        @(negedge clk);
        valid = 1'b1; cmd = c; p1 = a; p2 = b;
        tick();
        e0 = edge_n;
        valid = 1'b0;
        check("ack", 32'(ack), 1);
        check("busy_start", 32'(busy), rej ? 0 : 1);
        check_gates();
        if (rej) begin
            tick();
            check("ack_drop", 32'(ack), 0);
            check_all();
        end else begin
            for (int k = 1; k <= NV; k++) begin
                tick();
                if (k == 1) check("ack_drop", 32'(ack), 0);
                check("busy_scan", 32'(busy), 1);
                check_gates();
            end
            model_commit(e0, c, int'(a), int'(b));
            tick();
            check("busy_end", 32'(busy), 0);
            check_all();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        check("rst_ack", 32'(ack), 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; cmd = '0; p1 = '0; p2 = '0; chan = 4'd0;
        model_reset();
        do_reset();

        // Single note-on: voice 0, middle C
        send(8'h90, 7'd60, 7'd100);
        check("t1_freq_c4", 32'(freq[15:0]), 261);
        check("t1_gate", 32'(gate), 32'b0001);

        // Fill all voices, then steal the oldest (voice 0)
        send(8'h90, 7'd62, 7'd90);
        send(8'h90, 7'd64, 7'd80);
        send(8'h90, 7'd67, 7'd70);
        send(8'h90, 7'd69, 7'd60);
        check("t2_steal_low", 32'(gate[0]), 0);
        idle(RT + 2);
        check("t2_steal_note", 32'(note[6:0]), 69);
        check("t2_steal_gate", 32'(gate), 32'b1111);

        // Same note twice retriggers voice 0 only
        do_reset();
        send(8'h90, 7'd60, 7'd100);
        send(8'h90, 7'd60, 7'd110);
        check("t3_retrig_low", 32'(gate), 32'b0000);
        idle(RT + 2);
        check("t3_retrig_gate", 32'(gate), 32'b0001);

        // Velocity-0 note-on releases but keeps pitch
        do_reset();
        send(8'h90, 7'd60, 7'd100);
        send(8'h90, 7'd62, 7'd100);
        send(8'h90, 7'd60, 7'd0);
        check("t4_gate", 32'(gate), 32'b0010);
        check("t4_note_kept", 32'(note[6:0]), 60);

        // Channel filtering, mod wheel, pitch bend
        chan = 4'd2;
        send(8'h93, 7'd60, 7'd100);
        send(8'hB2, 7'h01, 7'd20);
        check("t5_mod", 32'(mod), 20);
        send(8'hE2, 7'h00, 7'h7F);
        check("t5_bend", 32'(pb), 'h3F80);

        // All-notes-off
        chan = 4'd0;
        do_reset();
        send(8'h90, 7'd60, 7'd100);
        send(8'h90, 7'd62, 7'd100);
        send(8'h90, 7'd64, 7'd100);
        send(8'h90, 7'd67, 7'd100);
        send(8'hB0, 7'h7B, 7'd0);
        check("t6_all_off", 32'(gate), 0);

        // Reset during the second SCAN cycle aborts the event
        send(8'h90, 7'd72, 7'd50);
        @(negedge clk);
        valid = 1'b1; cmd = 8'h90; p1 = 7'd70; p2 = 7'd90;
        tick();
        valid = 1'b0;
        check("abort_ack", 32'(ack), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_all();
        check("abort_busy", 32'(busy), 0);
        check("abort_ack_low", 32'(ack), 0);
        idle(NV + 3);
        check_all();
        check("abort_no_write", 32'(note[6:0]), 0);

        // Randomized traffic
        chan = 4'd5;
        for (int n = 0; n < 150; n++) begin
            int r;
            logic [7:0] c;
            logic [6:0] a, b;
            r = $urandom_range(0, 99);
            a = 7'(58 + $urandom_range(0, 9));
            b = 7'($urandom_range(1, 127));
            if (r < 45) begin
                c = {4'h9, chan};
                if ($urandom_range(0, 7) == 0) b = 7'd0;
            end else if (r < 65) begin
                c = {4'h8, chan};
            end else if (r < 75) begin
                c = {4'hB, chan};
                if ($urandom_range(0, 4) == 0) a = 7'h7B;
                else a = ($urandom_range(0, 1) != 0) ? 7'h01 : 7'h07;
            end else if (r < 82) begin
                c = {4'hE, chan};
                a = 7'($urandom_range(0, 127));
            end else if (r < 88) begin
                c = {4'hA, chan};
            end else if (r < 94) begin
                c = {4'h9, chan + 4'd1};
            end else begin
                c = 8'($urandom_range(0, 127));
            end
            send(c, a, b);
            idle($urandom_range(0, 20));
        end
        idle(RT + 2);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
